// File: rtl/vec_reduce_seq_pkg.sv
// Shared types for the vector reduction engine: FSM states and op encodings.
package vec_reduce_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        OP_SUM = 1'b0,
        OP_MAX = 1'b1
    } op_t;

endpackage

// File: rtl/vec_reduce_seq_if.sv
// Control, write-port and result-handshake bundle for vec_reduce_seq.
interface vec_reduce_seq_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 6
);
    localparam int AW    = $clog2(DEPTH);
    localparam int SUM_W = WIDTH + AW;

    logic             init;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             op_sel;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;

    modport master (
        output init, wr_en, wr_addr, wr_data, start, op_sel, out_ready,
        input  busy, out_valid, out_sum
    );

    modport slave (
        input  init, wr_en, wr_addr, wr_data, start, op_sel, out_ready,
        output busy, out_valid, out_sum
    );
endinterface

// File: rtl/vec_reduce_alu.sv
// Single combine step: folds one entry into the running accumulator.
module vec_reduce_alu
    import vec_reduce_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SUM_W = 35
) (
    input  op_t              op,
    input  logic [SUM_W-1:0] acc,
    input  logic [WIDTH-1:0] entry,
    output logic [SUM_W-1:0] acc_next
);
    logic [SUM_W-1:0] entry_ext;

    assign entry_ext = SUM_W'(entry);

    // Sum adds the zero-extended entry; max keeps the larger unsigned value
    always_comb begin
        acc_next = acc;
        unique case (op)
            OP_SUM: acc_next = acc + entry_ext;
            OP_MAX: if (entry_ext > acc) acc_next = entry_ext;
        endcase
    end
endmodule

// File: rtl/vec_reduce_seq.sv
// Register file of DEPTH entries reduced sequentially (sum or unsigned max).
module vec_reduce_seq
    import vec_reduce_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 6
) (
    input logic         clk,
    input logic         reset,
    vec_reduce_seq_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int SUM_W = WIDTH + AW;

    logic [WIDTH-1:0] entries [DEPTH];
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] acc_next;
    logic [AW-1:0]    index;
    op_t              op_q;
    state_t           state;
    logic             busy_q;
    logic             out_valid_q;

    vec_reduce_alu #(
        .WIDTH(WIDTH),
        .SUM_W(SUM_W)
    ) u_alu (
        .op       (op_q),
        .acc      (acc),
        .entry    (entries[index]),
        .acc_next (acc_next)
    );

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc;

    // FSM, entry storage and accumulator. DONE spends one cycle raising
    // out_valid so the result appears DEPTH+1 cycles after the start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            acc         <= '0;
            index       <= '0;
            op_q        <= OP_SUM;
            for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.init) begin
                        for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= WIDTH'(i);
                    end else begin
                        if (bus.wr_en && (int'(bus.wr_addr) < DEPTH))
                            entries[bus.wr_addr] <= bus.wr_data;
                        if (bus.start) begin
                            op_q   <= op_t'(bus.op_sel);
                            acc    <= '0;
                            index  <= '0;
                            state  <= ACCUM;
                            busy_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    acc   <= acc_next;
                    index <= index + AW'(1);
                    if (index == AW'(DEPTH - 1)) state <= DONE;
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
